// File: rtl/median_sort_unit_pkg.sv
// rtl/median_sort_unit_pkg.sv - shared width default, state encodings and FSM type for the sorter
// Optional build macro: SORT_EARLY_EXIT_EN (define to stop after two consecutive swap-free phases).
`ifndef BITWIDTH
`define BITWIDTH 8
`endif

package median_sort_unit_pkg;

  localparam logic [1:0] SORT_IDLE = 2'd0;
  localparam logic [1:0] SORT_RUN  = 2'd1;
  localparam logic [1:0] SORT_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = SORT_IDLE,
    ST_SORT = SORT_RUN,
    ST_DONE = SORT_DONE
  } state_e;

endpackage

// File: rtl/sort_cmp_exchange.sv
// rtl/sort_cmp_exchange.sv - combinational compare-exchange cell; lo/hi are the lower/higher index outputs
module sort_cmp_exchange #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         desc,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         swapped
);

  // Equal values never swap, which keeps the network stable.
  assign swapped = desc ? (a < b) : (a > b);
  assign lo      = swapped ? b : a;
  assign hi      = swapped ? a : b;

endmodule

// File: rtl/median_sort_unit.sv
// rtl/median_sort_unit.sv - N-element odd-even transposition sorter, one phase per clock, with median tap
// Optional build macro: SORT_EARLY_EXIT_EN (early exit after two consecutive swap-free phases).
module median_sort_unit #(
  parameter int N = 9,
  parameter int W = `BITWIDTH
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           start_i,
  input  logic           desc_i,
  input  logic [N*W-1:0] in_data_i,
  output logic [N*W-1:0] out_data_o,
  output logic [W-1:0]   median_o,
  output logic           busy_o,
  output logic           valid_o
);
  import median_sort_unit_pkg::*;

  localparam int              PW         = $clog2(N);
  localparam int              NP         = N / 2;
  localparam logic [PW-1:0]   LAST_PHASE = PW'(N - 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic            desc_q, desc_d;
  logic [W-1:0]    elem_q [N];
  logic [W-1:0]    elem_d [N];

  logic [W-1:0]    cell_a  [NP];
  logic [W-1:0]    cell_b  [NP];
  logic [W-1:0]    cell_lo [NP];
  logic [W-1:0]    cell_hi [NP];
  logic [NP-1:0]   cell_sw;
  logic [W-1:0]    even_net [N];
  logic [W-1:0]    odd_net  [N];

  // Each cell serves pair (2i,2i+1) on even phases and (2i+1,2i+2) on odd phases.
  for (genvar i = 0; i < NP; i++) begin : g_cell
    assign cell_a[i]       = phase_q[0] ? elem_q[2*i+1] : elem_q[2*i];
    assign even_net[2*i]   = cell_lo[i];
    assign even_net[2*i+1] = cell_hi[i];
    if (2*i+2 < N) begin : g_full
      assign cell_b[i]        = phase_q[0] ? elem_q[2*i+2] : elem_q[2*i+1];
      assign odd_net[2*i+1]   = cell_lo[i];
      assign odd_net[2*i+2]   = cell_hi[i];
    end else begin : g_tail
      assign cell_b[i]        = elem_q[2*i+1];
      assign odd_net[2*i+1]   = elem_q[2*i+1];
    end
    sort_cmp_exchange #(.W(W)) u_cmp (
      .a       (cell_a[i]),
      .b       (cell_b[i]),
      .desc    (desc_q),
      .lo      (cell_lo[i]),
      .hi      (cell_hi[i]),
      .swapped (cell_sw[i])
    );
  end

  assign odd_net[0] = elem_q[0];
  if (N % 2 == 1) begin : g_even_tail
    assign even_net[N-1] = elem_q[N-1];
  end

`ifdef SORT_EARLY_EXIT_EN
  logic noswap_q, noswap_d;
  logic any_swap;
  assign any_swap = |cell_sw;
`else
  logic [NP-1:0] unused_sw;
  assign unused_sw = cell_sw;
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    desc_d  = desc_q;
    elem_d  = elem_q;
`ifdef SORT_EARLY_EXIT_EN
    noswap_d = noswap_q;
`endif
    case (state_q)
      ST_SORT: begin
        for (int k = 0; k < N; k++) begin
          elem_d[k] = phase_q[0] ? odd_net[k] : even_net[k];
        end
        if (phase_q == LAST_PHASE) begin
          state_d = ST_DONE;
        end else begin
          phase_d = phase_q + PW'(1);
        end
`ifdef SORT_EARLY_EXIT_EN
        noswap_d = ~any_swap;
        if (noswap_q && !any_swap) state_d = ST_DONE;
`endif
      end
      default: begin
        if (start_i) begin
          for (int k = 0; k < N; k++) begin
            elem_d[k] = in_data_i[k*W +: W];
          end
          desc_d  = desc_i;
          phase_d = '0;
          state_d = ST_SORT;
`ifdef SORT_EARLY_EXIT_EN
          noswap_d = 1'b0;
`endif
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      desc_q  <= 1'b0;
      for (int k = 0; k < N; k++) elem_q[k] <= '0;
`ifdef SORT_EARLY_EXIT_EN
      noswap_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      desc_q  <= desc_d;
      elem_q  <= elem_d;
`ifdef SORT_EARLY_EXIT_EN
      noswap_q <= noswap_d;
`endif
    end
  end

  always_comb begin
    out_data_o = '0;
    for (int k = 0; k < N; k++) begin
      out_data_o[k*W +: W] = elem_q[k];
    end
  end

  assign median_o = elem_q[(N-1)/2];
  assign busy_o   = (state_q == ST_SORT);
  assign valid_o  = (state_q == ST_DONE);

endmodule

// File: tb/tb_median_sort_unit.sv
// tb/tb_median_sort_unit.sv - scoreboard bench for median_sort_unit at N=9/W=8 and N=4/W=12
module tb_median_sort_unit;

`ifdef SORT_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RST;

  logic        s1, d1;
  logic [71:0] in1;
  logic [71:0] out1;
  logic [7:0]  med1;
  logic        busy1, val1;

  logic        s2, d2;
  logic [47:0] in2;
  logic [47:0] out2;
  logic [11:0] med2;
  logic        busy2, val2;

  median_sort_unit #(.N(9), .W(8)) u_dut9 (
    .CLK(CLK), .RST(RST), .start_i(s1), .desc_i(d1), .in_data_i(in1),
    .out_data_o(out1), .median_o(med1), .busy_o(busy1), .valid_o(val1)
  );

  median_sort_unit #(.N(4), .W(12)) u_dut4 (
    .CLK(CLK), .RST(RST), .start_i(s2), .desc_i(d2), .in_data_i(in2),
    .out_data_o(out2), .median_o(med2), .busy_o(busy2), .valid_o(val2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] exp_q [$];

  function automatic logic [127:0] pack(input int v [$], input int w);
    logic [127:0] r = '0;
    for (int k = 0; k < v.size(); k++) r |= (128'(v[k]) << (k*w));
    return r;
  endfunction

  // Reference model: insertion sort on plain integers.
  function automatic logic [127:0] ref_sort(input logic [127:0] v, input int n, input int w, input bit d);
    int e [$];
    int tmp;
    int j;
    logic [127:0] mask = (128'd1 << w) - 128'd1;
    for (int k = 0; k < n; k++) e.push_back(int'((v >> (k*w)) & mask));
    for (int i = 1; i < n; i++) begin
      j = i;
      while (j > 0 && (d ? (e[j-1] < e[j]) : (e[j-1] > e[j]))) begin
        tmp = e[j]; e[j] = e[j-1]; e[j-1] = tmp;
        j--;
      end
    end
    return pack(e, w);
  endfunction

  function automatic int nel(input int sel);  return sel ? 4 : 9;  endfunction
  function automatic int wel(input int sel);  return sel ? 12 : 8; endfunction
  function automatic logic [127:0] obs_out(input int sel); return sel ? 128'(out2) : 128'(out1); endfunction
  function automatic logic [127:0] obs_med(input int sel); return sel ? 128'(med2) : 128'(med1); endfunction
  function automatic logic obs_valid(input int sel); return sel ? val2 : val1; endfunction
  function automatic logic obs_busy(input int sel);  return sel ? busy2 : busy1; endfunction

  function automatic logic [127:0] exp_median(input logic [127:0] v, input int sel);
    return (v >> (((nel(sel)-1)/2) * wel(sel))) & ((128'd1 << wel(sel)) - 128'd1);
  endfunction

  task automatic set_in(input int sel, input bit st, input logic [127:0] v, input bit d);
    if (sel != 0) begin s2 = st; in2 = v[47:0]; d2 = d; end
    else          begin s1 = st; in1 = v[71:0]; d1 = d; end
  endtask

  task automatic check_result(input int sel, input string name);
    logic [127:0] e;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s_scoreboard: valid_o with no expected entry", name);
      return;
    end
    e = exp_q.pop_front();
    n_checks++;
    if (obs_out(sel) !== e) begin
      n_fail++;
      $display("FAIL %s_data: got %0h expected %0h", name, obs_out(sel), e);
    end
    n_checks++;
    if (obs_med(sel) !== exp_median(e, sel)) begin
      n_fail++;
      $display("FAIL %s_median: got %0h expected %0h", name, obs_med(sel), exp_median(e, sel));
    end
  endtask

  task automatic run_sort(input int sel, input logic [127:0] v, input bit d, input int exp_lat, input string name);
    int lat = -1;
    @(negedge CLK);
    set_in(sel, 1'b1, v, d);
    exp_q.push_back(ref_sort(v, nel(sel), wel(sel), d));
    @(posedge CLK); #1;
    set_in(sel, 1'b0, v, d);
    n_checks++;
    if (obs_busy(sel) !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_busy: got %b expected 1", name, obs_busy(sel));
    end
    for (int c = 1; c <= 64; c++) begin
      @(posedge CLK); #1;
      if (obs_valid(sel) === 1'b1) begin lat = c; break; end
    end
    if (lat < 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: no valid_o within 64 cycles", name);
      void'(exp_q.pop_front());
      return;
    end
    check_result(sel, name);
    if (exp_lat >= 0) begin
      n_checks++;
      if (lat != exp_lat) begin
        n_fail++;
        $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
      end
    end
    @(posedge CLK); #1;
    n_checks++;
    if (obs_valid(sel) !== 1'b0 || obs_busy(sel) !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_pulse: valid %b busy %b expected 0 0", name, obs_valid(sel), obs_busy(sel));
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    s1 = 0; d1 = 0; in1 = '0;
    s2 = 0; d2 = 0; in2 = '0;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if ({out1, med1, busy1, val1} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut9: got %0h expected 0", {out1, med1, busy1, val1});
    end
    n_checks++;
    if ({out2, med2, busy2, val2} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut4: got %0h expected 0", {out2, med2, busy2, val2});
    end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_asc_desc();
    int q [$];
    q = {9, 3, 7, 1, 4, 6, 8, 2, 5};
    run_sort(0, pack(q, 8), 1'b0, EE ? -1 : 9, "asc");
    n_checks++;
    if (med1 !== 8'd5) begin n_fail++; $display("FAIL asc_median5: got %0d expected 5", med1); end
    run_sort(0, pack(q, 8), 1'b1, EE ? -1 : 9, "desc");
    n_checks++;
    if (med1 !== 8'd5) begin n_fail++; $display("FAIL desc_median5: got %0d expected 5", med1); end
  endtask

  task automatic test_sorted();
    int q [$];
    q = {1, 2, 3, 4, 5, 6, 7, 8, 9};
    run_sort(0, pack(q, 8), 1'b0, EE ? 2 : 9, "sorted");
  endtask

  task automatic test_duplicates();
    int q [$];
    q = {5, 5, 0, 255, 5, 0, 255, 5, 5};
    run_sort(0, pack(q, 8), 1'b0, EE ? -1 : 9, "dups");
    n_checks++;
    if ($isunknown({out1, med1, busy1, val1})) begin
      n_fail++;
      $display("FAIL dups_xcheck: got %0h expected no X", {out1, med1, busy1, val1});
    end
  endtask

  task automatic test_ignore_start();
    int q [$];
    int r [$];
    int nv = 0;
    int vc = -1;
    q = {20, 10, 40, 30, 60, 50, 80, 70, 90};
    r = {1, 1, 1, 1, 1, 1, 1, 1, 1};
    @(negedge CLK);
    set_in(0, 1'b1, pack(q, 8), 1'b0);
    exp_q.push_back(ref_sort(pack(q, 8), 9, 8, 1'b0));
    @(posedge CLK); #1;
    set_in(0, 1'b0, pack(q, 8), 1'b0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      set_in(0, (c == 3 || c == 5), pack(r, 8), 1'b1);
      @(posedge CLK); #1;
      if (val1 === 1'b1) begin
        nv++; vc = c;
        check_result(0, "ignore");
      end
    end
    set_in(0, 1'b0, pack(r, 8), 1'b0);
    n_checks++;
    if (nv != 1) begin n_fail++; $display("FAIL ignore_count: got %0d valid pulses expected 1", nv); end
    if (!EE) begin
      n_checks++;
      if (vc != 9) begin n_fail++; $display("FAIL ignore_edge: got %0d expected 9", vc); end
    end
  endtask

  task automatic test_back_to_back();
    int a [$];
    int b [$];
    int nv = 0;
    int c1 = -1;
    int c2 = -1;
    a = {200, 7, 13, 99, 0, 150, 42, 3, 77};
    b = {8, 6, 4, 2, 9, 7, 5, 3, 1};
    @(negedge CLK);
    set_in(0, 1'b1, pack(a, 8), 1'b0);
    exp_q.push_back(ref_sort(pack(a, 8), 9, 8, 1'b0));
    exp_q.push_back(ref_sort(pack(b, 8), 9, 8, 1'b1));
    @(posedge CLK); #1;
    set_in(0, 1'b1, pack(b, 8), 1'b1);
    for (int c = 1; c <= 24; c++) begin
      @(negedge CLK);
      if (c > 10) set_in(0, 1'b0, pack(b, 8), 1'b1);
      @(posedge CLK); #1;
      if (val1 === 1'b1) begin
        nv++;
        if (nv == 1) c1 = c; else c2 = c;
        check_result(0, "b2b");
      end
    end
    n_checks++;
    if (nv != 2) begin n_fail++; $display("FAIL b2b_count: got %0d valid pulses expected 2", nv); end
    if (!EE) begin
      n_checks++;
      if (c2 - c1 != 10) begin n_fail++; $display("FAIL b2b_gap: got %0d expected 10", c2 - c1); end
    end
  endtask

  task automatic test_reset_mid(input int sel, input int rst_edge, input logic [127:0] v, input string name);
    int nv = 0;
    @(negedge CLK);
    set_in(sel, 1'b1, v, 1'b0);
    @(posedge CLK); #1;
    set_in(sel, 1'b0, v, 1'b0);
    repeat (rst_edge) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    n_checks++;
    if ({obs_out(sel), obs_med(sel), obs_busy(sel), obs_valid(sel)} !== '0) begin
      n_fail++;
      $display("FAIL %s_async_clear: got %0h expected 0", name, {obs_out(sel), obs_med(sel), obs_busy(sel), obs_valid(sel)});
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(posedge CLK); #1;
      if (obs_valid(sel) === 1'b1) nv++;
    end
    n_checks++;
    if (nv != 0) begin n_fail++; $display("FAIL %s_no_valid: got %0d pulses expected 0", name, nv); end
  endtask

  task automatic test_reset_recovery();
    int q [$];
    int p [$];
    q = {9, 3, 7, 1, 4, 6, 8, 2, 5};
    test_reset_mid(0, 4, pack(q, 8), "rst9");
    run_sort(0, pack(q, 8), 1'b0, EE ? -1 : 9, "rst9_after");
    p = {4095, 0, 17, 3};
    test_reset_mid(1, 2, pack(p, 12), "rst4");
    run_sort(1, pack(p, 12), 1'b0, EE ? -1 : 4, "n4");
    n_checks++;
    if (out2 !== {12'd4095, 12'd17, 12'd3, 12'd0} || med2 !== 12'd3) begin
      n_fail++;
      $display("FAIL n4_literal: got %0h/%0d expected fff011003000/3", out2, med2);
    end
  endtask

  initial begin
    test_reset();
    test_asc_desc();
    test_sorted();
    test_duplicates();
    test_ignore_start();
    test_back_to_back();
    test_reset_recovery();
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/median_sort_unit.md
# median_sort_unit

Parametrised sorter for the median-filter datapath. Sorts N unsigned W-bit samples, ascending or descending, using an odd-even transposition network with one phase per clock. Presents the full sorted vector and the median element. Successor to the fixed 9-element bubble sorter: it replaces that block in the window pipeline and also serves larger or smaller windows.

## Interface
- N, 9: number of elements; N ≥ 2. N need not be odd.
- W, `BITWIDTH (8): element width in bits, unsigned.
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- start_i  in  1  request a sort; sampled only when busy_o = 0.
- desc_i  in  1  order select, captured with start_i: 0 = ascending, 1 = descending.
- in_data_i  in  N*W  unsorted elements; element k is at bits [k*W +: W].
- out_data_o  out  N*W  sorted elements; element k is at bits [k*W +: W].
- median_o  out  W  equals element (N-1)/2 of out_data_o.
- busy_o  out  1  high while a sort is in progress.
- valid_o  out  1  one-cycle pulse that marks a completed sort.

## Operation
- States: IDLE, SORT, DONE.
- IDLE:
  - When start_i = 1, register in_data_i into the element array, capture desc_i, clear phase to 0 and go to SORT.
  - When start_i = 0, hold.
- SORT: each cycle applies phase p.
  - Even p compares pairs (0,1), (2,3), …
  - Odd p compares pairs (1,2), (3,4), …
  - Unpaired end elements pass through unchanged.
  - Swap rule: swap when a > b (ascending) or a < b (descending), where a is the lower index. Equal values never swap.
  - After phase N-1 has been applied, go to DONE.
- DONE:
  - valid_o = 1 for this cycle only.
  - busy_o = 0.
  - A start_i in DONE is accepted exactly as in IDLE, so back-to-back sorts need no idle gap.
  - Without a start, go to IDLE.
- out_data_o and median_o are driven directly from the element array. They are stable and valid from DONE until the next accepted start, and change during SORT.
- start_i while busy_o = 1 is ignored. in_data_i and desc_i are not re-sampled.
- Reset in any state:
  - state goes to IDLE, phase to 0, the element array to 0;
  - valid_o = 0, busy_o = 0, out_data_o = 0, median_o = 0.
  - An in-flight sort is discarded and produces no valid_o.

## Timing
- Edge 0: start_i is sampled high and the inputs are captured.
- Edges 1..N: phases 0..N-1 are applied.
- valid_o is high between edge N and edge N+1. Latency is N cycles from the capture edge.
- busy_o is high from edge 0 to edge N.
- Throughput: one sort per N+1 cycles when start_i is held high continuously.
- Phase counter width: $clog2(N). It never exceeds N-1.

## Configuration
- Macro: SORT_EARLY_EXIT_EN.
- Defined:
  - Each phase produces a swap flag, which is the OR over all compare-exchange cells.
  - If two consecutive phases produce no swap, go to DONE immediately. Two phases are required because one no-swap phase alone does not prove the array is sorted.
  - Minimum latency is 2; maximum latency stays N.
  - valid_o and busy_o semantics are unchanged.
- Undefined: latency is always exactly N, independent of the data, and the swap-flag logic is not built.

## Structure
- Shared header common.vh holds:
  - the `BITWIDTH default;
  - the state encodings SORT_IDLE, SORT_RUN, SORT_DONE (2 bits);
  - the macro SORT_EARLY_EXIT_EN, commented out by default.
- One sub-module, sort_cmp_exchange: combinational. Ports: a, b, desc, lo, hi, swapped. Instantiate it floor(N/2) times with a generate loop and mux the pairings by phase parity.

## Test plan
- N=9, W=8, asc, input 9 3 7 1 4 6 8 2 5 → output 1 2 3 4 5 6 7 8 9, median_o = 5, valid_o at edge 9, single pulse.
- Same input, desc_i = 1 → output 9 8 7 6 5 4 3 2 1, median_o = 5.
- Already-sorted input 1..9, asc:
  - with SORT_EARLY_EXIT_EN, valid_o at edge 2;
  - without it, valid_o at edge 9;
  - output is identical in both cases.
- Duplicates 5 5 0 255 5 0 255 5 5, asc → 0 0 5 5 5 5 5 255 255, median_o = 5. Check that no X appears on any output.
- Pulse start_i at edges 3 and 5 during a sort → ignored; exactly one valid_o. Holding start_i high through DONE → the second sort is captured in DONE and its valid_o comes N+1 cycles after the first.
- Assert RST low at edge 4 of a sort → all outputs 0 immediately, no valid_o. After release, a new sort completes normally. Repeat with N=4 and W=12, input 4095 0 17 3 → 0 3 17 4095, median_o = 3.
